// File: rtl/aurora_reset_seq_if.sv
// Signal bundle between the Aurora bring-up sequencer and the transceiver/MAC side.
// master = sequencer (drives resets and status), slave = transceiver/MAC environment.
interface aurora_reset_seq_if;
  logic        gt_pll_lock;
  logic        channel_up;
  logic        soft_reset_req;
  logic        pma_init;
  logic        reset_pb;
  logic        link_ready;
  logic        link_fail;
  logic [7:0]  retry_cnt;
  logic [15:0] link_drop_cnt;

  modport master (
    input  gt_pll_lock, channel_up, soft_reset_req,
    output pma_init, reset_pb, link_ready, link_fail, retry_cnt, link_drop_cnt
  );

  modport slave (
    output gt_pll_lock, channel_up, soft_reset_req,
    input  pma_init, reset_pb, link_ready, link_fail, retry_cnt, link_drop_cnt
  );
endinterface

// File: rtl/aurora_reset_seq.sv
// Aurora link bring-up sequencer: pma_init -> reset_pb -> channel_up qualification, retry on timeout.
// Define AURORA_RST_DROP_CNT_EN to build the saturating link-drop counter; otherwise link_drop_cnt is 0.
module aurora_reset_seq #(
  parameter int PMA_HOLD_CYC     = 128,
  parameter int PB_DELAY_CYC     = 64,
  parameter int LINK_TIMEOUT_CYC = 1048576,
  parameter int MAX_RETRY        = 8
) (
  input  logic               pll_clk,
  input  logic               sync_rst_out_n,
  aurora_reset_seq_if.master bus
);

  localparam int MAX_P01 = (PMA_HOLD_CYC > PB_DELAY_CYC) ? PMA_HOLD_CYC : PB_DELAY_CYC;
  localparam int MAX_P   = (MAX_P01 > LINK_TIMEOUT_CYC) ? MAX_P01 : LINK_TIMEOUT_CYC;
  localparam int CW      = $clog2(MAX_P + 1);

  // PMA hold is measured from the entry edge inclusive, so cycle 0 after reset lands pma_init low at edge PMA_HOLD_CYC.
  localparam logic [CW-1:0] L_PMA_END  = CW'(PMA_HOLD_CYC);
  localparam logic [CW-1:0] L_PB_END   = CW'(PB_DELAY_CYC - 1);
  localparam logic [CW-1:0] L_LINK_END = CW'(LINK_TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_PMA_ASSERT,
    ST_PB_WAIT,
    ST_LINK_WAIT,
    ST_LINK_UP,
    ST_FAIL
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic retry_exhausted(input logic [7:0] n);
    return (MAX_RETRY != 0) && (int'(n) >= MAX_RETRY);
  endfunction

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_pma;
  logic          r_pb;
  logic          r_ready;
  logic          r_fail;
  logic [7:0]    r_retry;
  logic          r_cu_p0;
  logic [7:0]    w_retry_inc;

  assign w_retry_inc = sat_inc8(r_retry);

  always_ff @(posedge pll_clk) begin
    if (!sync_rst_out_n) begin
      r_state <= ST_PMA_ASSERT;
      r_cnt   <= '0;
      r_pma   <= 1'b1;
      r_pb    <= 1'b1;
      r_ready <= 1'b0;
      r_fail  <= 1'b0;
      r_retry <= '0;
      r_cu_p0 <= 1'b0;
    end else begin
      r_cu_p0 <= bus.channel_up;
      if (bus.soft_reset_req) begin
        r_state <= ST_PMA_ASSERT;
        r_cnt   <= '0;
        r_pma   <= 1'b1;
        r_pb    <= 1'b1;
        r_ready <= 1'b0;
        r_fail  <= 1'b0;
        r_retry <= '0;
      end else if (!bus.gt_pll_lock && (r_state == ST_LINK_WAIT || r_state == ST_LINK_UP)) begin
        // Losing PLL lock is not a link timeout, so retry_cnt is left untouched.
        r_state <= ST_PMA_ASSERT;
        r_cnt   <= '0;
        r_pma   <= 1'b1;
        r_pb    <= 1'b1;
        r_ready <= 1'b0;
      end else begin
        case (r_state)
          ST_PMA_ASSERT: begin
            if (r_cnt == L_PMA_END) begin
              r_state <= ST_PB_WAIT;
              r_cnt   <= '0;
              r_pma   <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_PB_WAIT: begin
            if (bus.gt_pll_lock) begin
              if (r_cnt == L_PB_END) begin
                r_state <= ST_LINK_WAIT;
                r_cnt   <= '0;
                r_pb    <= 1'b0;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          ST_LINK_WAIT: begin
            // Qualification is checked first so a simultaneous timeout still resolves to LINK_UP.
            if (bus.channel_up && r_cu_p0) begin
              r_state <= ST_LINK_UP;
              r_cnt   <= '0;
              r_ready <= 1'b1;
              r_retry <= '0;
            end else if (r_cnt == L_LINK_END) begin
              r_cnt   <= '0;
              r_retry <= w_retry_inc;
              r_pma   <= 1'b1;
              r_pb    <= 1'b1;
              if (retry_exhausted(w_retry_inc)) begin
                r_state <= ST_FAIL;
                r_fail  <= 1'b1;
              end else begin
                r_state <= ST_PMA_ASSERT;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_LINK_UP: begin
            if (!bus.channel_up) begin
              r_state <= ST_LINK_WAIT;
              r_cnt   <= '0;
              r_ready <= 1'b0;
            end
          end
          ST_FAIL: begin
            r_cnt <= '0;
          end
          default: begin
            r_state <= ST_PMA_ASSERT;
            r_cnt   <= '0;
            r_pma   <= 1'b1;
            r_pb    <= 1'b1;
            r_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pma_init   = r_pma;
  assign bus.reset_pb   = r_pb;
  assign bus.link_ready = r_ready;
  assign bus.link_fail  = r_fail;
  assign bus.retry_cnt  = r_retry;

`ifdef AURORA_RST_DROP_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        w_drop;
  logic [15:0] r_drop_cnt;

  // A drop is any exit from LINK_UP other than a soft reset (channel loss or PLL lock loss).
  assign w_drop = !bus.soft_reset_req && (r_state == ST_LINK_UP) &&
                  (!bus.gt_pll_lock || !bus.channel_up);

  always_ff @(posedge pll_clk) begin
    if (!sync_rst_out_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_drop_cnt <= sat_inc16(r_drop_cnt);
    end
  end

  assign bus.link_drop_cnt = r_drop_cnt;
`else
  assign bus.link_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_aurora_reset_seq.sv
// Bench for aurora_reset_seq: event-level reference model feeds a scoreboard queue, a monitor checks every edge.
module tb_aurora_reset_seq;
  localparam int PMA_HOLD = 128;
  localparam int PB_DELAY = 64;
  localparam int TIMEOUT  = 1000;
  localparam int MAXR     = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aurora_reset_seq_if bus();

  aurora_reset_seq #(
    .PMA_HOLD_CYC    (PMA_HOLD),
    .PB_DELAY_CYC    (PB_DELAY),
    .LINK_TIMEOUT_CYC(TIMEOUT),
    .MAX_RETRY       (MAXR)
  ) dut (
    .pll_clk       (clk),
    .sync_rst_out_n(rst_n),
    .bus           (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the link is in one of a few phases, each with a countdown to its next event.
  localparam int PH_HOLD = 0, PH_DELAY = 1, PH_LINKWAIT = 2, PH_UP = 3, PH_DEAD = 4;
  int m_ph, m_left, m_retry, m_drop;
  bit m_prev;

  typedef struct packed {
    logic        pma;
    logic        pb;
    logic        rdy;
    logic        fail;
    logic [7:0]  retry;
    logic [15:0] drop;
  } exp_t;
  exp_t sb_q[$];

  function automatic void m_enter(input int ph);
    m_ph = ph;
    case (ph)
      PH_HOLD:     m_left = PMA_HOLD;
      PH_DELAY:    m_left = PB_DELAY;
      PH_LINKWAIT: m_left = TIMEOUT;
      default:     m_left = 0;
    endcase
  endfunction

  function automatic void m_drop_event();
`ifdef AURORA_RST_DROP_CNT_EN
    if (m_drop < 65535) m_drop++;
`endif
  endfunction

  function automatic void model_step(input bit rstn, input bit lock, input bit cu, input bit srr);
    bit   qual;
    exp_t e;
    if (!rstn) begin
      m_enter(PH_HOLD);
      m_retry = 0;
      m_drop  = 0;
      m_prev  = 0;
    end else begin
      qual   = cu && m_prev;
      m_prev = cu;
      if (srr) begin
        m_enter(PH_HOLD);
        m_retry = 0;
      end else if (!lock && (m_ph == PH_LINKWAIT || m_ph == PH_UP)) begin
        if (m_ph == PH_UP) m_drop_event();
        m_enter(PH_HOLD);
      end else begin
        case (m_ph)
          PH_HOLD:  if (m_left == 0) m_enter(PH_DELAY); else m_left--;
          PH_DELAY: if (lock) begin
                      m_left--;
                      if (m_left == 0) m_enter(PH_LINKWAIT);
                    end
          PH_LINKWAIT: begin
            if (qual) begin
              m_enter(PH_UP);
              m_retry = 0;
            end else begin
              m_left--;
              if (m_left == 0) begin
                if (m_retry < 255) m_retry++;
                if (MAXR != 0 && m_retry >= MAXR) m_enter(PH_DEAD);
                else m_enter(PH_HOLD);
              end
            end
          end
          PH_UP: if (!cu) begin
                   m_drop_event();
                   m_enter(PH_LINKWAIT);
                 end
          default: ;
        endcase
      end
    end
    e.pma   = (m_ph == PH_HOLD) || (m_ph == PH_DEAD);
    e.pb    = (m_ph == PH_HOLD) || (m_ph == PH_DELAY) || (m_ph == PH_DEAD);
    e.rdy   = (m_ph == PH_UP);
    e.fail  = (m_ph == PH_DEAD);
    e.retry = 8'(m_retry);
    e.drop  = 16'(m_drop);
    sb_q.push_back(e);
  endfunction

  // Drive the inputs sampled at the next edge and queue the model's answer for that edge.
  task automatic step(input bit rstn, input bit lock, input bit cu, input bit srr);
    @(negedge clk);
    rst_n              = rstn;
    bus.gt_pll_lock    = lock;
    bus.channel_up     = cu;
    bus.soft_reset_req = srr;
    model_step(rstn, lock, cu, srr);
  endtask

  task automatic at_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_pma_init",      bus.pma_init,      e.pma);
        chk("sb_reset_pb",      bus.reset_pb,      e.pb);
        chk("sb_link_ready",    bus.link_ready,    e.rdy);
        chk("sb_link_fail",     bus.link_fail,     e.fail);
        chk("sb_retry_cnt",     bus.retry_cnt,     e.retry);
        chk("sb_link_drop_cnt", bus.link_drop_cnt, e.drop);
      end
    end
  end

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_pma"},   bus.pma_init,      1);
    chk({nm, "_pb"},    bus.reset_pb,      1);
    chk({nm, "_rdy"},   bus.link_ready,    0);
    chk({nm, "_fail"},  bus.link_fail,     0);
    chk({nm, "_retry"}, bus.retry_cnt,     0);
    chk({nm, "_drop"},  bus.link_drop_cnt, 0);
  endtask

  // Cycle c = c-th edge after reset release; channel_up first sampled high at edge 251.
  task automatic bringup(input string nm);
    for (int c = 0; c < 256; c++) begin
      step(1, 1, (c >= 251), 0);
      if (c == 127 || c == 128 || c == 191 || c == 192 || c == 251 || c == 252) begin
        at_edge();
        case (c)
          127: chk({nm, "_pma_hi_127"}, bus.pma_init,   1);
          128: chk({nm, "_pma_lo_128"}, bus.pma_init,   0);
          191: chk({nm, "_pb_hi_191"},  bus.reset_pb,   1);
          192: chk({nm, "_pb_lo_192"},  bus.reset_pb,   0);
          251: chk({nm, "_rdy_lo_251"}, bus.link_ready, 0);
          default: chk({nm, "_rdy_hi_252"}, bus.link_ready, 1);
        endcase
      end
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int          seen[$];
    logic [7:0]  last;
    bit          lk, cu, srr, rn;
    int          hold;
    int          exp_drop;

    rst_n = 1'b0;
    bus.gt_pll_lock = 1'b0;
    bus.channel_up = 1'b0;
    bus.soft_reset_req = 1'b0;

`ifdef AURORA_RST_DROP_CNT_EN
    exp_drop = 1;
`else
    exp_drop = 0;
`endif

    // Reset values, then nominal bring-up.
    repeat (3) step(0, 1, 0, 0);
    at_edge();
    chk_reset_vals("rst");
    bringup("s1");

    // One-cycle channel drop while up.
    step(1, 1, 0, 0); at_edge(); chk("drop_rdy_fall", bus.link_ready, 0);
    step(1, 1, 1, 0); at_edge(); chk("drop_rdy_wait", bus.link_ready, 0);
    step(1, 1, 1, 0); at_edge(); chk("drop_rdy_back", bus.link_ready, 1);
    chk("drop_cnt", bus.link_drop_cnt, exp_drop);

    // Lock held low until edge 300: reset_pb delayed, pma_init unaffected.
    repeat (2) step(0, 0, 0, 0);
    for (int c = 0; c < 366; c++) begin
      step(1, (c >= 301), 0, 0);
      if (c == 128 || c == 363 || c == 364) begin
        at_edge();
        if (c == 128) chk("s2_pma_lo_128", bus.pma_init, 0);
        else if (c == 363) chk("s2_pb_hi_363", bus.reset_pb, 1);
        else chk("s2_pb_lo_364", bus.reset_pb, 0);
      end
    end

    // channel_up never rises: retries step to MAX_RETRY then FAIL.
    last = 8'd0;
    for (int i = 0; i < 4000 && bus.link_fail !== 1'b1; i++) begin
      step(1, 1, 0, 0);
      at_edge();
      if (bus.retry_cnt !== last) begin
        seen.push_back(int'(bus.retry_cnt));
        last = bus.retry_cnt;
      end
    end
    chk("s3_link_fail", bus.link_fail, 1);
    chk("s3_num_steps", seen.size(), MAXR);
    for (int k = 0; k < seen.size(); k++) chk("s3_retry_step", seen[k], k + 1);
    chk("s3_pma_held", bus.pma_init, 1);
    for (int i = 0; i < 20; i++) step(1, 1, 1'($urandom_range(0, 1)), 0);
    at_edge();
    chk("s3_fail_sticky", bus.link_fail, 1);

    // Soft reset out of FAIL, full sequence repeats.
    step(1, 1, 0, 1);
    at_edge();
    chk("s4_fail_clr", bus.link_fail, 0);
    chk("s4_retry_clr", bus.retry_cnt, 0);
    chk("s4_pma_hi", bus.pma_init, 1);
    for (int c = 1; c <= 260; c++) step(1, 1, (c >= 220), 0);
    at_edge();
    chk("s4_link_up", bus.link_ready, 1);

    // Reset in PB_WAIT after one timeout: everything returns to reset values.
    repeat (2) step(0, 1, 0, 0);
    for (int c = 0; c < 1350; c++) step(1, 1, 0, 0);
    at_edge();
    chk("s6_retry_pre", bus.retry_cnt, 1);
    chk("s6_in_pbwait", {bus.pma_init, bus.reset_pb}, 2'b01);
    step(0, 1, 0, 0);
    at_edge();
    chk_reset_vals("s6_rst");
    bringup("s6");

    // Randomized traffic: channel flaps, lock loss, soft resets and occasional resets.
    lk = 1; cu = 0; hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        cu   = !cu;
        hold = ($urandom_range(0, 9) == 0) ? int'($urandom_range(500, 1300)) : int'($urandom_range(0, 60));
      end else begin
        hold--;
      end
      if ($urandom_range(0, 199) == 0) lk = 0;
      else if (!lk && $urandom_range(0, 7) == 0) lk = 1;
      srr = ($urandom_range(0, 1499) == 0);
      rn  = ($urandom_range(0, 2999) != 0);
      step(rn, lk, cu, srr);
    end

    repeat (2) @(posedge clk);
    #2;
    chk("sb_drain", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aurora_reset_seq.md
# aurora_reset_seq

Aurora link bring-up sequencer. It sits directly downstream of the global reset synchronizer and consumes its synchronized active-low reset. It drives the transceiver `pma_init` and Aurora `reset_pb` in the mandated order, qualifies `channel_up`, and retries on timeout. It exports link-ready and failure status to the MAC.

## Interface

Parameters:
- `PMA_HOLD_CYC`, 128: cycles `pma_init` is held high per attempt (≥1).
- `PB_DELAY_CYC`, 64: cycles after `pma_init` release, with `gt_pll_lock` high, before `reset_pb` release (≥1).
- `LINK_TIMEOUT_CYC`, 1048576: cycles allowed for `channel_up` after `reset_pb` release (≥2).
- `MAX_RETRY`, 8: consecutive timeouts before FAIL; 0 means retry forever.

Ports:
- `pll_clk`, in, 1: sole clock.
- `sync_rst_out_n`, in, 1: **already decided** — synchronous reset, active low.
- `gt_pll_lock`, in, 1: transceiver PLL lock, already synchronous to `pll_clk`.
- `channel_up`, in, 1: Aurora channel up, synchronous to `pll_clk`.
- `soft_reset_req`, in, 1: single-cycle request to restart the sequence.
- `pma_init`, out, 1: transceiver PMA reset, active high.
- `reset_pb`, out, 1: Aurora push-button reset, active high.
- `link_ready`, out, 1: qualified link up.
- `link_fail`, out, 1: sticky; retries exhausted.
- `retry_cnt`, out, 8: consecutive timeouts in the current bring-up, saturating at 255.
- `link_drop_cnt`, out, 16: link-drop events (see Configuration).

## Operation

- States: PMA_ASSERT, PB_WAIT, LINK_WAIT, LINK_UP, FAIL. One cycle counter, width `$clog2(max param + 1)`, cleared on every state change.
- Reset (`sync_rst_out_n`=0 at an edge):
  - state=PMA_ASSERT, counter=0.
  - `pma_init`=1, `reset_pb`=1.
  - `link_ready`=0, `link_fail`=0, `retry_cnt`=0, `link_drop_cnt`=0.
- PMA_ASSERT:
  - `pma_init`=1 and `reset_pb`=1.
  - After `PMA_HOLD_CYC` cycles, go to PB_WAIT with `pma_init`=0.
- PB_WAIT:
  - Counter advances only while `gt_pll_lock`=1; it holds otherwise and is not cleared.
  - At `PB_DELAY_CYC`, go to LINK_WAIT with `reset_pb`=0.
- LINK_WAIT:
  - `channel_up` high on two consecutive samples: go to LINK_UP, set `link_ready`=1, clear `retry_cnt`.
  - Counter reaching `LINK_TIMEOUT_CYC` before that: increment `retry_cnt` (saturating).
  - If `MAX_RETRY`≠0 and the new `retry_cnt` ≥ `MAX_RETRY`: go to FAIL. Otherwise go to PMA_ASSERT, reasserting `pma_init` and `reset_pb`.
- LINK_UP:
  - `channel_up`=0: go to LINK_WAIT with a fresh timer, `link_ready`=0, `reset_pb` stays low.
  - Each such drop increments `link_drop_cnt`.
- FAIL:
  - `pma_init`=1, `reset_pb`=1, `link_fail`=1, `link_ready`=0.
  - Exits only on reset or `soft_reset_req`.
- Priority, highest first:
  1. Reset.
  2. `soft_reset_req`: from any state go to PMA_ASSERT; clears `retry_cnt` and `link_fail`; `link_drop_cnt` kept.
  3. `gt_pll_lock`=0 in LINK_WAIT or LINK_UP: go to PMA_ASSERT; no `retry_cnt` increment; `link_drop_cnt` increments if leaving LINK_UP.
  4. Per-state transitions.
- A timeout and channel-up qualification in the same cycle resolve to LINK_UP.

## Timing

- All outputs are registered and change on the `pll_clk` edge that enters the new state.
- Cycle 0 is the first edge with `sync_rst_out_n`=1.
- `pma_init` falls at edge `PMA_HOLD_CYC`.
- With lock already high, `reset_pb` falls at edge `PMA_HOLD_CYC+PB_DELAY_CYC`.
- `link_ready` rises on the edge after the second consecutive `channel_up` sample, i.e. 2 edges after `channel_up` rises.
- `link_ready` falls 1 edge after `channel_up` is sampled low.
- `soft_reset_req` reasserts `pma_init`/`reset_pb` on the next edge.
- Mid-sequence reset: outputs return to their reset values on that edge; no partial state is retained.

## Configuration

- `AURORA_RST_DROP_CNT_EN` defined: `link_drop_cnt` is a 16-bit counter, saturating at 0xFFFF, cleared only by reset.
- Undefined: the counter logic is absent and `link_drop_cnt` is tied to 0. All other behaviour is identical.

## Test plan

- **Reset release, lock=1, `channel_up` at edge 250** (params 128/64/1000/8): `pma_init` falls at edge 128, `reset_pb` at edge 192, `link_ready` rises at edge 252.
- **Lock low until edge 300**: `reset_pb` falls at edge 364. `pma_init` still falls at edge 128.
- **`channel_up` never rises** (`MAX_RETRY`=3, timeout 1000): `retry_cnt` steps 1, 2, 3; `link_fail`=1 after the third timeout; `pma_init`=1 held.
- **`soft_reset_req` pulse while in FAIL**: next edge `link_fail`=0, `retry_cnt`=0, `pma_init`=1; the full sequence repeats.
- **In LINK_UP, `channel_up` low for 1 cycle then high**: `link_ready` drops 1 edge later and returns 2 edges after recovery. `link_drop_cnt`=1 with the macro, 0 without.
- **`sync_rst_out_n` low mid-PB_WAIT**: all outputs return to reset values on the next edge; the sequence restarts cleanly.
